wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single integer register-file write port between the in-order pipeline writeback stage and the long-latency result path (multiply/divide and late load returns). Long-latency results are buffered in a small FIFO and written in idle writeback slots. A starvation counter forces a drain slot by stalling the pipeline for one cycle. The block sits between the WB stage, the long-latency unit and the register file.

## Interface
Parameters:
- DEPTH, 4 — pending-result FIFO entries (power of two, ≥2)
- STARVE_MAX, 8 — cycles a non-empty FIFO may wait before a forced drain (1..255)

Ports:
- clk  in  1  — single clock, rising edge
- reset  in  1  — asynchronous, active-low; all state clears while low
- pipe_valid  in  1  — WB stage has a register write this cycle
- pipe_rd  in  5  — WB destination register
- pipe_data  in  32  — WB write data
- pipe_stall  out  1  — combinational; 1 = WB slot taken by forced drain, pipeline holds
- lu_valid  in  1  — long-latency result offered
- lu_ready  out  1  — combinational; 1 = FIFO accepts (count < DEPTH)
- lu_rd  in  5  — long-latency destination register
- lu_data  in  32  — long-latency result
- chk_rs  in  5  — scoreboard query register
- chk_hit  out  1  — combinational; 1 = a valid FIFO entry targets chk_rs, chk_rs ≠ 0
- rf_we  out  1  — registered register-file write enable
- rf_rd  out  5  — registered write address
- rf_data  out  32  — registered write data

## Operation
- Enqueue on lu_valid && lu_ready; lu_valid with lu_ready = 0 is held by the producer and not lost. No enqueue when full.
- States: ST_NORM, ST_FORCE. Reset → ST_NORM.
- ST_NORM grant priority: (1) pipe_valid → pipeline; (2) FIFO non-empty → FIFO head; (3) nothing.
- starve counter: +1 each cycle FIFO is non-empty and not granted; cleared on FIFO grant or when empty; saturates at STARVE_MAX.
- starve == STARVE_MAX with FIFO non-empty → ST_FORCE. In ST_FORCE: grant FIFO head, pipe_stall = 1 (pipeline data ignored, presented again next cycle), then return to ST_NORM. Exactly one forced write per entry into ST_FORCE.
- pipe_stall = 1 only in ST_FORCE.
- A granted write with rd = 0 (%g0) is consumed (FIFO pops, counter clears) but rf_we = 0.
- chk_hit compares all valid entries, excluding a head popping this cycle.
- Enqueue and dequeue in the same cycle: count unchanged. Both pointers wrap modulo DEPTH.

## Timing
- Reset values: rf_we = 0, rf_rd = 0, rf_data = 0, count = 0, pointers = 0, starve = 0, state = ST_NORM; pipe_stall = 0, lu_ready = 1, chk_hit = 0.
- Pipeline write: granted in cycle N → rf_* valid after edge N (one-cycle latency).
- FIFO path: enqueued at edge N → earliest grant in cycle N+1 → rf_we after edge N+1.
- Reset asserted mid-operation discards all buffered entries; the producer re-issues after reset.

## Configuration
- WB_ARB_BYPASS_EN defined: when the FIFO is empty, pipe_valid = 0, state = ST_NORM and lu_valid = 1, the result is granted directly that cycle. It is not enqueued, and rf_* are valid after the same edge. lu_ready stays as defined.
- Undefined: every long-latency result passes through the FIFO; minimum latency is two edges.

## Structure
- Package wb_pkg: REG_W = 5, DATA_W = 32, typedef wb_req_t {rd, data}, enum arb_state_e {ST_NORM, ST_FORCE}.
- Sub-module wb_fifo: parameterised DEPTH of wb_req_t, push/pop/full/empty/count, plus a per-entry valid/rd vector for chk_hit. Arbitration, FSM and output registers live in wb_port_arbiter.

## Test plan
- Reset low mid-traffic with 3 entries buffered → all outputs at reset values, lu_ready = 1; after release, the first write comes from new traffic only.
- pipe_valid = 0, lu_rd = 5, lu_data = 0x1234 offered once → rf_we = 1, rf_rd = 5, rf_data = 0x1234 two edges later (one edge with WB_ARB_BYPASS_EN).
- pipe_valid held 1 and one FIFO entry (rd = 7) → pipe writes for 8 cycles, then pipe_stall = 1 for one cycle and rd 7 is written; the pipeline write resumes the next cycle.
- 4 long results with pipe_valid = 1 → lu_ready = 0 after the 4th; a 5th is held and enqueued in the cycle after the first drain.
- FIFO holds rd = 0 then rd = 3; pipe idle → rd 0 popped with rf_we = 0, next cycle rd 3 written.
- FIFO holds rd = 9; chk_rs = 9 → chk_hit = 1; chk_rs = 0 → 0; after rd 9 drains → 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, write-request type and arbiter state encoding.
package wb_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;
    typedef enum logic {ST_NORM, ST_FORCE} arb_state_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: pending long-latency results, with per-entry valid/rd taps for the
// register scoreboard query.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  wb_req_t                      wr_req,
    output wb_req_t                      head,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][REG_W-1:0]  ent_rd
);
    localparam int AW = $clog2(DEPTH);
    wb_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
    logic [AW:0] count_q, count_d;
    logic full, do_push, do_pop;
    always_comb begin
        full = count_q == (AW+1)'(DEPTH);
        empty = count_q == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wr_req;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head = mem_q[rd_ptr_q];
        count = count_q;
        off = '0;
        // a head leaving this cycle no longer blocks a reader
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr_q;
            ent_valid[i] = ({1'b0, off} < count_q) && !(do_pop && off == '0);
            ent_rd[i] = mem_q[i].rd;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RF write port between WB and buffered long-latency results.
// Define WB_ARB_BYPASS_EN to let a result skip an empty FIFO when the WB slot is idle.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_valid,
    input  logic [REG_W-1:0]  pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_W-1:0]  lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    input  logic [REG_W-1:0]  chk_rs,
    output logic              chk_hit,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_rd,
    output logic [DATA_W-1:0] rf_data
);
    localparam int CW = $clog2(DEPTH) + 1;
    arb_state_e state_q, state_d;
    logic [7:0] starve_q, starve_d;
    logic rf_we_q, rf_we_d;
    logic [REG_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic fifo_empty, push, grant_pipe, grant_fifo, bypass, grant;
    logic [CW-1:0] fifo_count;
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0][REG_W-1:0] ent_rd;
    wb_req_t head, req;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (grant_fifo),
        .wr_req    (wb_req_t'({lu_rd, lu_data})),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    always_comb begin
        pipe_stall = state_q == ST_FORCE;
        lu_ready = fifo_count != CW'(DEPTH);
        grant_pipe = !pipe_stall && pipe_valid;
        grant_fifo = !fifo_empty && (pipe_stall || !pipe_valid);
`ifdef WB_ARB_BYPASS_EN
        bypass = !pipe_stall && !pipe_valid && fifo_empty && lu_valid;
`else
        bypass = 1'b0;
`endif
        grant = grant_pipe || grant_fifo || bypass;
        push = lu_valid && lu_ready && !bypass;
        req = grant_pipe ? wb_req_t'({pipe_rd, pipe_data}) :
              grant_fifo ? head : wb_req_t'({lu_rd, lu_data});
        rf_we_d = grant && req.rd != '0;
        rf_rd_d = grant ? req.rd : rf_rd_q;
        rf_data_d = grant ? req.data : rf_data_q;
        starve_d = (fifo_empty || grant_fifo) ? '0 :
                   (starve_q == 8'(STARVE_MAX)) ? starve_q : starve_q + 8'd1;
        // the forced slot follows the cycle in which the counter reaches its limit
        state_d = (!pipe_stall && !fifo_empty && !grant_fifo && starve_d == 8'(STARVE_MAX))
                  ? ST_FORCE : ST_NORM;
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) chk_hit = chk_hit || (ent_valid[i] && ent_rd[i] == chk_rs);
        chk_hit = chk_hit && chk_rs != '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_NORM;
            starve_q <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q <= state_d;
            starve_q <= starve_d;
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_rd = rf_rd_q;
    assign rf_data = rf_data_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios and random traffic checked against a queue model.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic clk = 1'b0;
    logic reset;
    logic pipe_valid, lu_valid, pipe_stall, lu_ready, chk_hit, rf_we;
    logic [4:0] pipe_rd, lu_rd, chk_rs, rf_rd;
    logic [31:0] pipe_data, lu_data, rf_data;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .chk_rs(chk_rs), .chk_hit(chk_hit),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int starve;
    bit force_m, acc;
    int n_cmp, n_fail;

`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // One clock: model predicts from the pending queue, DUT checked before and after the edge.
    task automatic cycle();
        bit e_stall, e_ready, e_hit, gp, gf, gb, e_we, was_empty;
        logic [4:0] e_rd;
        logic [31:0] e_data;
        e_stall = force_m;
        e_ready = q.size() < DEPTH;
        gf = force_m || (!pipe_valid && q.size() > 0);
        gp = !force_m && pipe_valid;
        gb = BYP && !force_m && !pipe_valid && q.size() == 0 && lu_valid;
        e_hit = 1'b0;
        for (int i = gf ? 1 : 0; i < q.size(); i++) if (q[i].rd == chk_rs) e_hit = 1'b1;
        if (chk_rs == 5'd0) e_hit = 1'b0;
        e_rd = gp ? pipe_rd : gf ? q[0].rd : lu_rd;
        e_data = gp ? pipe_data : gf ? q[0].data : lu_data;
        e_we = (gp || gf || gb) && e_rd != 5'd0;
        #1;
        n_cmp += 3;
        if (pipe_stall !== e_stall) begin n_fail++; $display("FAIL pipe_stall: got %b want %b t=%0t", pipe_stall, e_stall, $time); end
        if (lu_ready !== e_ready) begin n_fail++; $display("FAIL lu_ready: got %b want %b t=%0t", lu_ready, e_ready, $time); end
        if (chk_hit !== e_hit) begin n_fail++; $display("FAIL chk_hit: got %b want %b rs=%0d t=%0t", chk_hit, e_hit, chk_rs, $time); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (rf_we !== e_we) begin n_fail++; $display("FAIL rf_we: got %b want %b t=%0t", rf_we, e_we, $time); end
        if (e_we) begin
            n_cmp++;
            if ({rf_rd, rf_data} !== {e_rd, e_data}) begin
                n_fail++;
                $display("FAIL rf_write: got rd=%0d data=%h want rd=%0d data=%h t=%0t", rf_rd, rf_data, e_rd, e_data, $time);
            end
        end
        was_empty = q.size() == 0;
        if (gf) void'(q.pop_front());
        acc = lu_valid && e_ready && !gb;
        if (acc) q.push_back('{lu_rd, lu_data});
        if (was_empty || gf) starve = 0;
        else if (starve < SMAX) starve++;
        force_m = !was_empty && !gf && starve == SMAX;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        pipe_valid = 1'b0;
        lu_valid = 1'b0;
        while ((q.size() > 0 || force_m) && n < 2 * DEPTH + 4) begin cycle(); n++; end
        cycle();
    endtask

    task automatic test_reset();
        pipe_valid = 1'b1;
        pipe_rd = 5'd17;
        pipe_data = 32'hdead_beef;
        lu_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            lu_rd = 5'(i);
            lu_data = $urandom;
            cycle();
        end
        lu_valid = 1'b0;
        pipe_valid = 1'b0;
        chk_rs = 5'd2;
        reset = 1'b0;
        #1;
        n_cmp += 6;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
        if (rf_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rf_rd: got %0d want 0", rf_rd); end
        if (rf_data !== 32'd0) begin n_fail++; $display("FAIL rst_rf_data: got %h want 0", rf_data); end
        if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL rst_pipe_stall: got %b want 0", pipe_stall); end
        if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lu_ready: got %b want 1", lu_ready); end
        if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL rst_chk_hit: got %b want 0", chk_hit); end
        q.delete();
        starve = 0;
        force_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cycle();
        lu_valid = 1'b1;
        lu_rd = 5'd12;
        lu_data = 32'h0bad_f00d;
        cycle();
        lu_valid = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic test_fifo_latency();
        drain();
        lu_valid = 1'b1;
        lu_rd = 5'd5;
        lu_data = 32'h1234;
        cycle();
        lu_valid = 1'b0;
        n_cmp++;
        if (rf_we !== BYP) begin n_fail++; $display("FAIL lat_first_edge: got we=%b want %b", rf_we, BYP); end
        if (!BYP) cycle();
        n_cmp++;
        if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd5, 32'h1234}) begin
            n_fail++;
            $display("FAIL lat_write: got we=%b rd=%0d data=%h want 1/5/1234", rf_we, rf_rd, rf_data);
        end
    endtask

    task automatic test_starve();
        int n = 0;
        drain();
        pipe_valid = 1'b1;
        pipe_rd = 5'd20;
        pipe_data = 32'hcafe_0020;
        lu_valid = 1'b1;
        lu_rd = 5'd7;
        lu_data = 32'h7777;
        cycle();
        lu_valid = 1'b0;
        while (!pipe_stall && n < 20) begin cycle(); n++; end
        n_cmp++;
        if (n !== SMAX) begin n_fail++; $display("FAIL starve_pipe_cycles: got %0d want %0d", n, SMAX); end
        cycle();
        n_cmp++;
        if ({rf_we, rf_rd} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL forced_write: got we=%b rd=%0d want 1/7", rf_we, rf_rd); end
        cycle();
        n_cmp++;
        if ({rf_we, rf_rd, pipe_stall} !== {1'b1, 5'd20, 1'b0}) begin
            n_fail++;
            $display("FAIL pipe_resume: got we=%b rd=%0d stall=%b want 1/20/0", rf_we, rf_rd, pipe_stall);
        end
    endtask

    task automatic test_full();
        int j = 0, stall_j = -1, acc_j = -1;
        drain();
        pipe_valid = 1'b1;
        pipe_rd = 5'd21;
        lu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lu_rd = 5'(i + 1);
            lu_data = $urandom;
            cycle();
        end
        n_cmp++;
        if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", lu_ready); end
        lu_rd = 5'd30;
        lu_data = 32'h5555_aaaa;
        while (acc_j < 0 && j < 30) begin
            if (pipe_stall && stall_j < 0) stall_j = j;
            if (lu_ready) acc_j = j;
            cycle();
            j++;
        end
        n_cmp++;
        if (acc_j < 0 || acc_j != stall_j + 1) begin
            n_fail++;
            $display("FAIL held_enqueue: got accept at %0d want %0d", acc_j, stall_j + 1);
        end
        lu_valid = 1'b0;
        drain();
    endtask

    task automatic test_rd0();
        drain();
        pipe_valid = 1'b1;
        pipe_rd = 5'd22;
        lu_valid = 1'b1;
        lu_rd = 5'd0;
        lu_data = 32'h0000_1111;
        cycle();
        lu_rd = 5'd3;
        lu_data = 32'h0000_3333;
        cycle();
        lu_valid = 1'b0;
        pipe_valid = 1'b0;
        cycle();
        n_cmp++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got %b want 0", rf_we); end
        cycle();
        n_cmp++;
        if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd3, 32'h0000_3333}) begin
            n_fail++;
            $display("FAIL rd3_after_rd0: got we=%b rd=%0d data=%h want 1/3/3333", rf_we, rf_rd, rf_data);
        end
    endtask

    task automatic test_chk();
        drain();
        pipe_valid = 1'b1;
        pipe_rd = 5'd23;
        lu_valid = 1'b1;
        lu_rd = 5'd9;
        lu_data = 32'h9999;
        cycle();
        lu_valid = 1'b0;
        chk_rs = 5'd9;
        #1;
        n_cmp++;
        if (chk_hit !== 1'b1) begin n_fail++; $display("FAIL chk_hit9: got %b want 1", chk_hit); end
        cycle();
        chk_rs = 5'd0;
        #1;
        n_cmp++;
        if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL chk_hit0: got %b want 0", chk_hit); end
        cycle();
        pipe_valid = 1'b0;
        chk_rs = 5'd9;
        cycle();
        #1;
        n_cmp++;
        if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL chk_after_drain: got %b want 0", chk_hit); end
        cycle();
    endtask

    task automatic test_random();
        drain();
        acc = 1'b0;
        for (int k = 0; k < 500; k++) begin
            pipe_valid = $urandom_range(0, 99) < 65;
            pipe_rd = 5'($urandom_range(0, 31));
            pipe_data = $urandom;
            if (!lu_valid || acc) begin
                lu_valid = $urandom_range(0, 99) < 45;
                lu_rd = 5'($urandom_range(0, 15));
                lu_data = $urandom;
            end
            chk_rs = 5'($urandom_range(0, 15));
            cycle();
        end
        drain();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        q.delete();
        starve = 0;
        force_m = 1'b0;
        acc = 1'b0;
        pipe_valid = 1'b0;
        pipe_rd = '0;
        pipe_data = '0;
        lu_valid = 1'b0;
        lu_rd = '0;
        lu_data = '0;
        chk_rs = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_fifo_latency();
        test_starve();
        test_full();
        test_rd0();
        test_chk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
